// File: rtl/npu_layer_seq.sv
// npu_layer_seq: host-bus layer sequencer for an N_STAGE chain of NPU compute stages.
// Decodes region/offset writes into one-hot loads or soft-reset/trigger/require commands, sequences
// stage_start/stage_done hand-offs, tracks busy/done/err and captures the last stage's result.
// Ports: clk, rst (sync, active-high); host_we/host_addr/host_wdata in; host_rdata/host_rvalid out;
// ld_we/ld_addr/ld_data load bus out; stage_start out, stage_done/stage_result in;
// soft_rst, busy, done, err, err_code status out.
// Optional: define NPU_SEQ_TIMEOUT_EN to add a per-stage TIMEOUT watchdog (err_code bit 1, ERR state).
module npu_layer_seq #(
  parameter int N_STAGE   = 4,
  parameter int AW_REGION = 3,
  parameter int AW_OFF    = 12,
  parameter int DW        = 8,
  parameter int RES_W     = 24,
  parameter int TIMEOUT   = 65535
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        host_we,
  input  logic [AW_REGION+AW_OFF-1:0] host_addr,
  input  logic [DW-1:0]               host_wdata,
  output logic [RES_W-1:0]            host_rdata,
  output logic                        host_rvalid,
  output logic [N_STAGE:0]            ld_we,
  output logic [AW_OFF-1:0]           ld_addr,
  output logic [DW-1:0]               ld_data,
  output logic [N_STAGE-1:0]          stage_start,
  input  logic [N_STAGE-1:0]          stage_done,
  input  logic [RES_W-1:0]            stage_result,
  output logic                        soft_rst,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [1:0]                  err_code
);

  localparam int KW = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;
  localparam int AW = AW_REGION + AW_OFF;
  localparam int LW = N_STAGE + 1;
  localparam logic [AW_REGION-1:0] LAST_LD = AW_REGION'(N_STAGE);
  localparam logic [AW_REGION-1:0] CMD_REG = AW_REGION'(N_STAGE + 1);

  if (N_STAGE < 1 || N_STAGE > 6 || N_STAGE + 1 >= 2**AW_REGION || TIMEOUT < 1) begin : g_bad_cfg
    $error("npu_layer_seq: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t             r_state, w_state_n;
  logic [KW-1:0]      r_k, w_k_n;
  logic [RES_W-1:0]   r_res, w_res_n;
  logic [1:0]         r_err, w_err_n;
  logic [N_STAGE:0]   r_ld_we, w_ld_we_n;
  logic [AW_OFF-1:0]  r_ld_addr, w_ld_addr_n;
  logic [DW-1:0]      r_ld_data, w_ld_data_n;
  logic [N_STAGE-1:0] r_start, w_start_n;
  logic               r_srst, w_srst_n;
  logic               r_rvalid, w_rvalid_n;
  logic [RES_W-1:0]   r_rdata, w_rdata_n;

  logic [AW_REGION-1:0] w_region;
  logic [AW_OFF-1:0]    w_off;
  logic w_load, w_cmd, w_srst, w_trig, w_req;
  logic w_kdone, w_klast;

`ifdef NPU_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt, w_cnt_n;
`endif

  assign w_region = host_addr[AW-1:AW_OFF];
  assign w_off    = host_addr[AW_OFF-1:0];
  assign w_load   = host_we & (w_region <= LAST_LD);
  assign w_cmd    = host_we & (w_region == CMD_REG);
  assign w_srst   = w_cmd & (w_off == AW_OFF'(0));
  assign w_trig   = w_cmd & (w_off == AW_OFF'(1));
  assign w_req    = w_cmd & (w_off == AW_OFF'(2));

  // Only the active stage's done bit is honoured.
  assign w_kdone = |(stage_done & (N_STAGE'(1) << r_k));
  assign w_klast = (r_k == KW'(N_STAGE - 1));

  always_comb begin
    w_state_n   = r_state;
    w_k_n       = r_k;
    w_res_n     = r_res;
    w_err_n     = r_err;
    w_ld_we_n   = '0;
    w_ld_addr_n = r_ld_addr;
    w_ld_data_n = r_ld_data;
    w_start_n   = '0;
    w_srst_n    = 1'b0;
    w_rvalid_n  = 1'b0;
    w_rdata_n   = '0;
`ifdef NPU_SEQ_TIMEOUT_EN
    w_cnt_n     = r_cnt;
`endif
    if (w_req) begin
      w_rvalid_n = 1'b1;
      w_rdata_n  = (r_state == S_DONE) ? r_res
                 : RES_W'({r_err, r_state, 3'(r_k)});
    end
    // Soft reset overrides any same-cycle stage hand-off.
    if (w_srst) begin
      w_state_n = S_IDLE;
      w_k_n     = '0;
      w_res_n   = '0;
      w_err_n   = '0;
      w_srst_n  = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_load) begin
            w_ld_we_n   = LW'(1) << w_region;
            w_ld_addr_n = w_off;
            w_ld_data_n = host_wdata;
          end else if (w_trig) begin
            w_state_n = S_RUN;
            w_k_n     = '0;
            w_res_n   = '0;
            w_start_n = N_STAGE'(1);
`ifdef NPU_SEQ_TIMEOUT_EN
            w_cnt_n   = '0;
`endif
          end
        end
        S_RUN: begin
          if (w_load || w_trig) w_err_n[0] = 1'b1;
          if (w_kdone) begin
            if (w_klast) begin
              w_res_n   = stage_result;
              w_state_n = S_DONE;
            end else begin
              w_k_n     = r_k + KW'(1);
              w_start_n = N_STAGE'(1) << (r_k + KW'(1));
`ifdef NPU_SEQ_TIMEOUT_EN
              w_cnt_n   = '0;
`endif
            end
          end
`ifdef NPU_SEQ_TIMEOUT_EN
          // A done arriving on the expiry cycle is handled above and wins.
          else if (r_cnt == CW'(TIMEOUT - 1)) begin
            w_err_n[1] = 1'b1;
            w_state_n  = S_ERR;
          end else begin
            w_cnt_n = r_cnt + CW'(1);
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_res     <= '0;
      r_err     <= '0;
      r_ld_we   <= '0;
      r_ld_addr <= '0;
      r_ld_data <= '0;
      r_start   <= '0;
      r_srst    <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
`ifdef NPU_SEQ_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      r_state   <= w_state_n;
      r_k       <= w_k_n;
      r_res     <= w_res_n;
      r_err     <= w_err_n;
      r_ld_we   <= w_ld_we_n;
      r_ld_addr <= w_ld_addr_n;
      r_ld_data <= w_ld_data_n;
      r_start   <= w_start_n;
      r_srst    <= w_srst_n;
      r_rvalid  <= w_rvalid_n;
      r_rdata   <= w_rdata_n;
`ifdef NPU_SEQ_TIMEOUT_EN
      r_cnt     <= w_cnt_n;
`endif
    end
  end

  assign host_rdata  = r_rdata;
  assign host_rvalid = r_rvalid;
  assign ld_we       = r_ld_we;
  assign ld_addr     = r_ld_addr;
  assign ld_data     = r_ld_data;
  assign stage_start = r_start;
  assign soft_rst    = r_srst;
  assign busy        = (r_state == S_RUN);
  assign done        = (r_state == S_DONE);
  assign err         = |r_err;
  assign err_code    = r_err;

endmodule

// File: tb/tb_npu_layer_seq.sv
// tb_npu_layer_seq: randomized and directed bench for npu_layer_seq
// against a cycle-level behavioural model of the sequencer rules.
module tb_npu_layer_seq;
  localparam int N   = 4;
  localparam int AWR = 3;
  localparam int AWO = 12;
  localparam int DW  = 8;
  localparam int RW  = 24;
  localparam int TO  = 10;
  localparam int AW  = AWR + AWO;
  localparam int CMD = N + 1;
`ifdef NPU_SEQ_TIMEOUT_EN
  localparam bit TOEN = 1'b1;
`else
  localparam bit TOEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic [RW-1:0] host_rdata;
  logic host_rvalid;
  logic [N:0] ld_we;
  logic [AWO-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic [N-1:0] stage_start;
  logic [N-1:0] stage_done;
  logic [RW-1:0] stage_result;
  logic soft_rst, busy, done, err;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  npu_layer_seq #(
    .N_STAGE(N), .AW_REGION(AWR), .AW_OFF(AWO),
    .DW(DW), .RES_W(RW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .stage_start(stage_start), .stage_done(stage_done),
    .stage_result(stage_result),
    .soft_rst(soft_rst), .busy(busy), .done(done),
    .err(err), .err_code(err_code)
  );

  // stage stubs: done sampled L edges after start is sampled; L=0 never finishes
  int lat [N];
  int scnt [N];
  logic [N-1:0] stub_done = '0;
  logic [N-1:0] force_done = '0;
  logic [N-1:0] noise = '0;
  logic [RW-1:0] res_val = '0;
  assign stage_done = stub_done | force_done | noise;
  assign stage_result = res_val;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (stage_start[i]) scnt[i] = lat[i];
      else if (scnt[i] > 0) scnt[i] = scnt[i] - 1;
    end
    #1;
    for (int i = 0; i < N; i++) stub_done[i] = (scnt[i] == 1);
  end

  int starts[$];
  always @(negedge clk)
    for (int i = 0; i < N; i++)
      if (stage_start[i]) starts.push_back(i);

  // behavioural model; state codes 0 idle, 1 run, 2 done, 3 err
  int m_st = 0, m_k = 0, m_err = 0, m_t = 0;
  logic [31:0] m_res = 0;
  logic [N:0] e_ldwe = '0;
  int e_ldaddr = 0, e_lddata = 0, e_start = 0, e_srst = 0, e_rv = 0;
  logic [31:0] e_rdata = 0;

  always @(posedge clk) begin : model
    int rg, off;
    bit ld, cmd;
    rg = int'(host_addr) >> AWO;
    off = int'(host_addr) % (1 << AWO);
    e_ldwe = '0; e_start = 0; e_srst = 0; e_rv = 0; e_rdata = 0;
    if (rst) begin
      m_st = 0; m_k = 0; m_res = 0; m_err = 0; m_t = 0;
    end else begin
      ld = host_we && rg <= N;
      cmd = host_we && rg == CMD;
      if (cmd && off == 2) begin
        e_rv = 1;
        e_rdata = (m_st == 2) ? m_res : 32'(m_err * 32 + m_st * 8 + m_k);
      end
      if (cmd && off == 0) begin
        m_st = 0; m_k = 0; m_res = 0; m_err = 0; e_srst = 1;
      end else if (m_st == 0 || m_st == 2) begin
        if (ld) begin
          e_ldwe[rg] = 1'b1;
          e_ldaddr = off;
          e_lddata = int'(host_wdata);
        end else if (cmd && off == 1) begin
          m_st = 1; m_k = 0; m_res = 0; e_start = 1; m_t = 0;
        end
      end else if (m_st == 1) begin
        if (ld || (cmd && off == 1)) m_err = m_err | 1;
        if (stage_done[m_k]) begin
          if (m_k == N - 1) begin
            m_res = 32'(stage_result);
            m_st = 2;
          end else begin
            m_k = m_k + 1;
            e_start = 1 << m_k;
            m_t = 0;
          end
        end else if (TOEN) begin
          m_t = m_t + 1;
          if (m_t == TO) begin
            m_err = m_err | 2;
            m_st = 3;
          end
        end
      end
    end
  end

  int n_pass = 0, n_chk = 0;
  bit chk_en = 1'b0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ld_we", 32'(ld_we), 32'(e_ldwe));
      if (e_ldwe != 0) begin
        chk("ld_addr", 32'(ld_addr), 32'(e_ldaddr));
        chk("ld_data", 32'(ld_data), 32'(e_lddata));
      end
      chk("stage_start", 32'(stage_start), 32'(e_start));
      chk("soft_rst", 32'(soft_rst), 32'(e_srst));
      chk("rvalid", 32'(host_rvalid), 32'(e_rv));
      if (e_rv != 0) chk("rdata", 32'(host_rdata), e_rdata);
      chk("busy", 32'(busy), 32'(m_st == 1));
      chk("done", 32'(done), 32'(m_st == 2));
      chk("err", 32'(err), 32'(m_err != 0));
      chk("err_code", 32'(err_code), 32'(m_err));
    end
  end

  task automatic wr(int r, int o, int d);
    host_we = 1'b1;
    host_addr = AW'(r * (1 << AWO) + o);
    host_wdata = DW'(d);
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_start(int i, int lim);
    int c = 0;
    while (!stage_start[i] && c < lim) begin
      @(negedge clk);
      c++;
    end
    chk($sformatf("wait_start%0d", i), 32'(stage_start[i]), 32'd1);
  endtask

  task automatic wait_done(int lim);
    int c = 0;
    while (!done && c < lim) begin
      @(negedge clk);
      c++;
    end
    chk("wait_done", 32'(done), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    lat = '{3, 5, 2, 4};
    res_val = 24'h800001;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_outs", 32'({busy, done, err, soft_rst, host_rvalid}), 32'd0);
    chk("reset_ld_start", 32'({ld_we, stage_start, err_code}), 32'd0);

    // loads
    wr(0, 5, 8'h7F);
    chk("ld_img_we", 32'(ld_we), 32'h01);
    chk("ld_img_addr", 32'(ld_addr), 32'd5);
    chk("ld_img_data", 32'(ld_data), 32'h7F);
    wr(3, 1319, 8'h80);
    chk("ld_w2_we", 32'(ld_we), 32'h08);
    chk("ld_w2_addr", 32'(ld_addr), 32'd1319);
    chk("ld_w2_data", 32'(ld_data), 32'h80);

    // full run: 3+5+2+4 plus 4 hand-offs
    starts.delete();
    wr(CMD, 1, 0);
    chk("run_start0", 32'(stage_start), 32'h1);
    idle(17);
    chk("run_done_t17", 32'(done), 32'd0);
    idle(1);
    chk("run_done_t18", 32'(done), 32'd1);
    chk("run_cnt", 32'(starts.size()), 32'd4);
    for (int i = 0; i < starts.size(); i++)
      chk("run_order", 32'(starts[i]), 32'(i));
    wr(CMD, 2, 0);
    chk("req_rvalid", 32'(host_rvalid), 32'd1);
    chk("req_rdata", 32'(host_rdata), 32'h800001);

    // busy violation
    wr(CMD, 1, 0);
    idle(2);
    wr(0, 7, 8'h11);
    chk("busy_ld_we", 32'(ld_we), 32'd0);
    chk("busy_err", 32'(err_code), 32'd1);
    wr(CMD, 1, 0);
    wait_done(60);
    chk("busy_err_hold", 32'(err_code), 32'd1);
    wr(CMD, 0, 0);
    chk("srst_pulse", 32'(soft_rst), 32'd1);
    chk("srst_err", 32'(err), 32'd0);

    // soft reset together with the final stage_done
    lat[3] = 0;
    wr(CMD, 1, 0);
    wait_start(3, 60);
    force_done = 4'b1000;
    host_we = 1'b1;
    host_addr = AW'(CMD * (1 << AWO));
    @(negedge clk);
    host_we = 1'b0;
    force_done = '0;
    chk("sim_done", 32'(done), 32'd0);
    chk("sim_busy", 32'(busy), 32'd0);
    wr(CMD, 2, 0);
    chk("sim_rdata", 32'(host_rdata), 32'd0);
    lat[3] = 4;

    // status read mid-run at k=2
    lat[2] = 0;
    wr(CMD, 1, 0);
    wait_start(2, 60);
    wr(CMD, 2, 0);
    chk("mid_rdata", 32'(host_rdata), 32'h0A);
    wr(CMD, 0, 0);
    lat[2] = 2;

    // rst mid-run at k=1
    lat[1] = 0;
    wr(CMD, 1, 0);
    wait_start(1, 60);
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_outs", 32'({busy, done, err, soft_rst, host_rvalid, err_code}), 32'd0);
    chk("rst_ld_start", 32'({ld_we, stage_start}), 32'd0);
    lat[1] = 5;
    wr(CMD, 1, 0);
    chk("rst_restart", 32'(stage_start), 32'h1);
    wait_done(60);

`ifdef NPU_SEQ_TIMEOUT_EN
    lat[1] = 0;
    wr(CMD, 1, 0);
    wait_start(1, 60);
    idle(9);
    chk("to_before", 32'(err_code), 32'd0);
    idle(1);
    chk("to_code", 32'(err_code), 32'd2);
    chk("to_busy", 32'(busy), 32'd0);
    wr(CMD, 1, 0);
    chk("to_trig_ign", 32'({busy, stage_start}), 32'd0);
    wr(CMD, 0, 0);
    chk("to_srst", 32'(err_code), 32'd0);
    lat[1] = 5;
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0)
        for (int i = 0; i < N; i++) lat[i] = $urandom_range(0, 6);
      host_we = ($urandom % 3) == 0;
      if ($urandom % 2 == 1)
        host_addr = AW'(CMD * (1 << AWO) + $urandom_range(0, 3));
      else
        host_addr = AW'($urandom);
      host_wdata = DW'($urandom);
      noise = ($urandom % 8 == 0) ? N'($urandom) : '0;
      res_val = RW'($urandom);
      rst = ($urandom % 300 == 0);
      @(negedge clk);
    end
    host_we = 1'b0;
    noise = '0;
    rst = 1'b0;
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
